// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: 4-digit common-anode SSD driver with dead time, frame-synchronous update and zero blanking.
// Define SSD_BLINK_EN to add blink_mask and a free-running blink counter.
module ssd_scan_driver #(
    parameter int BLANK_CYCLES = 64,
    parameter bit LZ_SUPPRESS  = 1'b1
`ifdef SSD_BLINK_EN
    ,
    parameter int BLINK_BITS   = 24
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  scan_sel,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
`ifdef SSD_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);
    typedef enum logic {BLANK, DRIVE} state_t;
    localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);
    state_t      r_state;
    logic [1:0]  r_sel_q;
    logic [7:0]  r_cnt;
    logic [19:0] r_pending, r_active;
    logic        r_pending_valid;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp, r_frame_tick;
    logic        w_change, w_boundary, w_drive, w_lz, w_blink, w_dark;
    logic [15:0] w_val;
    logic [3:0]  w_nib, w_an;
    logic [6:0]  w_hex, w_seg;
    logic        w_dp;
`ifdef SSD_BLINK_EN
    logic [BLINK_BITS-1:0] r_blink;
    assign w_blink = r_blink[BLINK_BITS-1] & blink_mask[r_sel_q];
`else
    assign w_blink = 1'b0;
`endif
    assign w_change   = scan_sel != r_sel_q;
    assign w_boundary = (r_sel_q == 2'd3) && (scan_sel == 2'd0);
    assign w_drive    = r_state == DRIVE;
    assign w_val      = r_active[19:4];
    assign w_nib      = w_val[{r_sel_q, 2'b00} +: 4];
    assign w_lz       = LZ_SUPPRESS && ((r_sel_q == 2'd3 && w_val[15:12] == 4'd0) ||
                                        (r_sel_q == 2'd2 && w_val[15:8] == 8'd0) ||
                                        (r_sel_q == 2'd1 && w_val[15:4] == 12'd0));
    assign w_dark     = !w_drive || w_blink;
    assign w_an       = w_drive ? ~(4'b0001 << r_sel_q) : 4'b1111;
    assign w_seg      = (w_dark || w_lz) ? 7'b1111111 : w_hex;
    assign w_dp       = w_dark ? 1'b1 : ~r_active[r_sel_q];
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;
    always_comb begin
        w_hex = 7'b1111111;
        case (w_nib)
            4'h0: w_hex = 7'b1000000;
            4'h1: w_hex = 7'b1111001;
            4'h2: w_hex = 7'b0100100;
            4'h3: w_hex = 7'b0110000;
            4'h4: w_hex = 7'b0011001;
            4'h5: w_hex = 7'b0010010;
            4'h6: w_hex = 7'b0000010;
            4'h7: w_hex = 7'b1111000;
            4'h8: w_hex = 7'b0000000;
            4'h9: w_hex = 7'b0010000;
            4'hA: w_hex = 7'b0001000;
            4'hB: w_hex = 7'b0000011;
            4'hC: w_hex = 7'b1000110;
            4'hD: w_hex = 7'b0100001;
            4'hE: w_hex = 7'b0000110;
            default: w_hex = 7'b0001110;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= BLANK;
            r_sel_q         <= 2'd0;
            r_cnt           <= 8'd0;
            r_pending       <= 20'd0;
            r_active        <= 20'd0;
            r_pending_valid <= 1'b0;
            r_an            <= 4'b1111;
            r_seg           <= 7'b1111111;
            r_dp            <= 1'b1;
            r_frame_tick    <= 1'b0;
        end else begin
            r_sel_q      <= scan_sel;
            r_frame_tick <= w_boundary;
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            // a load landing on the boundary bypasses pending so it shows this frame
            if (load && w_boundary) begin
                r_active        <= {value, dp_in};
                r_pending       <= {value, dp_in};
                r_pending_valid <= 1'b0;
            end else if (load) begin
                r_pending       <= {value, dp_in};
                r_pending_valid <= 1'b1;
            end else if (w_boundary && r_pending_valid) begin
                r_active        <= r_pending;
                r_pending_valid <= 1'b0;
            end
            if (w_change) begin
                r_state <= BLANK;
                r_cnt   <= 8'd0;
            end else if (r_state == BLANK) begin
                if (r_cnt == CNT_LAST) r_state <= DRIVE;
                else r_cnt <= r_cnt + 8'd1;
            end
        end
    end
`ifdef SSD_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_blink <= '0;
        else r_blink <= r_blink + 1'b1;
    end
`endif
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: scoreboard bench for ssd_scan_driver with BLANK_CYCLES=4, LZ_SUPPRESS=1.
module tb_ssd_scan_driver;
    logic        clk = 1'b0;
    logic        rst, load;
    logic [1:0]  scan_sel;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_tick;
    typedef struct packed {logic [3:0] an; logic [6:0] seg; logic dp;} exp_t;
    localparam exp_t OFF = 12'hFFF;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    ssd_scan_driver #(.BLANK_CYCLES(4), .LZ_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst(rst), .scan_sel(scan_sel), .value(value), .dp_in(dp_in), .load(load),
`ifdef SSD_BLINK_EN
        .blink_mask(4'b0000),
`endif
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    function automatic exp_t digit_exp(input logic [15:0] v, input logic [3:0] d, input logic [1:0] k);
        logic blank;
        blank = (k == 2'd3 && v[15:12] == 4'd0) || (k == 2'd2 && v[15:8] == 8'd0) ||
                (k == 2'd1 && v[15:4] == 12'd0);
        return {~(4'b0001 << k), blank ? 7'b1111111 : hex7(v[{k, 2'b00} +: 4]), ~d[k]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_step(input logic [1:0] k, input logic ft, input logic ld,
                             input logic [15:0] v, input logic [3:0] d);
        exp_t e;
        scan_sel = k;
        if (ld) load = 1'b1;
        repeat (4) q.push_back(OFF);
        q.push_back(digit_exp(v, d, k));
        for (int i = 1; i <= 20; i++) begin
            step();
            load = 1'b0;
            if (i <= 2) begin
                checks++;
                if (frame_tick !== (i == 1 ? ft : 1'b0)) begin
                    errors++;
                    $display("FAIL frame_tick sel=%0d sample=%0d: got %b expected %b", k, i, frame_tick, i == 1 ? ft : 1'b0);
                end
            end
            if ((i >= 2 && i <= 5) || i == 20) begin
                e = q.pop_front();
                checks++;
                if ({an, seg, dp} !== e) begin
                    errors++;
                    $display("FAIL scan sel=%0d sample=%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                             k, i, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; scan_sel = 2'd0; load = 1'b0; value = 16'h0; dp_in = 4'h0;
        step(); step();
        checks++;
        if ({an, seg, dp, frame_tick} !== 13'b1111_1111111_1_0) begin
            errors++;
            $display("FAIL reset_state: got an=%b seg=%b dp=%b ft=%b expected 1111 1111111 1 0", an, seg, dp, frame_tick);
        end
        rst = 1'b0;
        repeat (4) q.push_back(OFF);
        q.push_back(digit_exp(16'h0000, 4'h0, 2'd0));
        for (int i = 1; i <= 5; i++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL reset_release sample=%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                         i, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_scan();
        value = 16'h12AF; dp_in = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        scan_step(2'd1, 1'b0, 1'b0, 16'h0000, 4'h0);
        scan_step(2'd2, 1'b0, 1'b0, 16'h0000, 4'h0);
        scan_step(2'd3, 1'b0, 1'b0, 16'h0000, 4'h0);
        scan_step(2'd0, 1'b1, 1'b0, 16'h12AF, 4'h0);
        scan_step(2'd1, 1'b0, 1'b0, 16'h12AF, 4'h0);
        scan_step(2'd2, 1'b0, 1'b0, 16'h12AF, 4'h0);
        scan_step(2'd3, 1'b0, 1'b0, 16'h12AF, 4'h0);
    endtask

    task automatic test_midframe_load();
        scan_step(2'd0, 1'b1, 1'b0, 16'h12AF, 4'h0);
        scan_step(2'd1, 1'b0, 1'b0, 16'h12AF, 4'h0);
        value = 16'h0007; load = 1'b1;
        step();
        load = 1'b0;
        scan_step(2'd2, 1'b0, 1'b0, 16'h12AF, 4'h0);
        scan_step(2'd3, 1'b0, 1'b0, 16'h12AF, 4'h0);
        scan_step(2'd0, 1'b1, 1'b0, 16'h0007, 4'h0);
        scan_step(2'd1, 1'b0, 1'b0, 16'h0007, 4'h0);
        scan_step(2'd2, 1'b0, 1'b0, 16'h0007, 4'h0);
        scan_step(2'd3, 1'b0, 1'b0, 16'h0007, 4'h0);
    endtask

    task automatic test_load_at_boundary();
        value = 16'hBCD0; dp_in = 4'b0101;
        scan_step(2'd0, 1'b1, 1'b1, 16'hBCD0, 4'b0101);
        scan_step(2'd1, 1'b0, 1'b0, 16'hBCD0, 4'b0101);
        scan_step(2'd2, 1'b0, 1'b0, 16'hBCD0, 4'b0101);
        scan_step(2'd3, 1'b0, 1'b0, 16'hBCD0, 4'b0101);
        value = 16'h0000; dp_in = 4'h0;
        scan_step(2'd0, 1'b1, 1'b0, 16'hBCD0, 4'b0101);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        repeat (6) q.push_back(OFF);
        q.push_back(digit_exp(16'hBCD0, 4'b0101, 2'd0));
        scan_sel = 2'd1;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL toggle_tick sample=%0d: got %b expected 0", i, frame_tick);
            end
            if (i >= 2) begin
                e = q.pop_front();
                checks++;
                if ({an, seg, dp} !== e) begin
                    errors++;
                    $display("FAIL toggle sample=%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                             i, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
            if (i == 2) scan_sel = 2'd0;
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        scan_step(2'd1, 1'b0, 1'b0, 16'hBCD0, 4'b0101);
        scan_step(2'd2, 1'b0, 1'b0, 16'hBCD0, 4'b0101);
        value = 16'h12AF; dp_in = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, dp, frame_tick} !== 13'b1111_1111111_1_0) begin
            errors++;
            $display("FAIL async_reset: got an=%b seg=%b dp=%b ft=%b expected 1111 1111111 1 0", an, seg, dp, frame_tick);
        end
        scan_sel = 2'd0;
        step(); step();
        rst = 1'b0;
        repeat (4) q.push_back(OFF);
        q.push_back(digit_exp(16'h0000, 4'h0, 2'd0));
        for (int i = 1; i <= 5; i++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL post_reset sample=%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                         i, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        scan_step(2'd1, 1'b0, 1'b0, 16'h0000, 4'h0);
        scan_step(2'd2, 1'b0, 1'b0, 16'h0000, 4'h0);
        scan_step(2'd3, 1'b0, 1'b0, 16'h0000, 4'h0);
        scan_step(2'd0, 1'b1, 1'b0, 16'h0000, 4'h0);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_load_at_boundary();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
